tdm_demux: RTL and testbench

Time-division demultiplexer. The inverse of the team's 4:1 2-bit multiplexer: it takes a framed stream of 2-bit symbols on one lane and distributes four consecutive beats into registered outputs A, B, C and D. Slot n goes to the output the multiplexer selects with SEL = n. It sits at the receiving end of a TDM link and presents whole frames atomically to downstream logic.

---
 rtl/tdm_demux.sv | 169 ++++++++++++++++
 tb/tb_tdm_demux.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: gathers four framed beats into registered A..D outputs.
// Optional COLLECT gap timeout is compiled in with `define TDM_DEMUX_TIMEOUT_EN.
module tdm_demux #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic [1:0]       sel,
  output logic             busy,
  output logic             frame_valid,
  output logic             frame_err
);

  typedef enum logic {IDLE = 1'b0, COLLECT = 1'b1} state_t;

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] s0_r, s1_r, s2_r;
  logic [WIDTH-1:0] s0_next_s, s1_next_s, s2_next_s;
  logic [1:0]       sel_r, sel_next_s;
  logic             commit_s, err_s, timeout_s;

`ifdef TDM_DEMUX_TIMEOUT_EN
  logic [2:0] gap_r, gap_next_s;
  assign timeout_s = (state_r == COLLECT) && !din_valid && (gap_r == 3'd7);
`else
  assign timeout_s = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (din_valid && frame_start) begin
          state_next_s = COLLECT;
        end else begin
          state_next_s = IDLE;
        end
      end
      COLLECT: begin
        if (din_valid && !frame_start && (sel_r == 2'd3)) begin
          state_next_s = IDLE;
        end else if (timeout_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = COLLECT;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath and pulse decode
  always_comb begin
    s0_next_s  = s0_r;
    s1_next_s  = s1_r;
    s2_next_s  = s2_r;
    sel_next_s = sel_r;
    commit_s   = 1'b0;
    err_s      = 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
    gap_next_s = gap_r;
`endif
    case (state_r)
      IDLE: begin
        if (din_valid && frame_start) begin
          s0_next_s  = din;
          sel_next_s = 2'd1;
`ifdef TDM_DEMUX_TIMEOUT_EN
          gap_next_s = 3'd0;
`endif
        end else begin
          sel_next_s = 2'd0;
        end
      end
      COLLECT: begin
        if (din_valid) begin
`ifdef TDM_DEMUX_TIMEOUT_EN
          gap_next_s = 3'd0;
`endif
          if (frame_start) begin
            // Restart discards the partial frame; A..D keep the last good frame
            err_s      = 1'b1;
            s0_next_s  = din;
            sel_next_s = 2'd1;
          end else begin
            case (sel_r)
              2'd0: begin s0_next_s = din; sel_next_s = 2'd1; end
              2'd1: begin s1_next_s = din; sel_next_s = 2'd2; end
              2'd2: begin s2_next_s = din; sel_next_s = 2'd3; end
              2'd3: begin commit_s = 1'b1; sel_next_s = 2'd0; end
              default: sel_next_s = 2'd0;
            endcase
          end
        end else if (timeout_s) begin
          err_s      = 1'b1;
          sel_next_s = 2'd0;
        end else begin
`ifdef TDM_DEMUX_TIMEOUT_EN
          gap_next_s = gap_r + 3'd1;
`endif
          sel_next_s = sel_r;
        end
      end
      default: sel_next_s = 2'd0;
    endcase
  end

  // Shadow, slot index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_r        <= {WIDTH{1'b0}};
      s1_r        <= {WIDTH{1'b0}};
      s2_r        <= {WIDTH{1'b0}};
      sel_r       <= 2'd0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      a           <= {WIDTH{1'b0}};
      b           <= {WIDTH{1'b0}};
      c           <= {WIDTH{1'b0}};
      d           <= {WIDTH{1'b0}};
    end else begin
      s0_r        <= s0_next_s;
      s1_r        <= s1_next_s;
      s2_r        <= s2_next_s;
      sel_r       <= sel_next_s;
      busy        <= (state_next_s == COLLECT);
      frame_valid <= commit_s;
      frame_err   <= err_s;
      if (commit_s) begin
        a <= s0_r;
        b <= s1_r;
        c <= s2_r;
        d <= din;
      end
    end
  end

`ifdef TDM_DEMUX_TIMEOUT_EN
  // Idle-beat gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 3'd0;
    end else begin
      gap_r <= gap_next_s;
    end
  end
`endif

  assign sel = sel_r;

endmodule

// File: tb/tb_tdm_demux.sv
// Scoreboard bench for tdm_demux: expected frames are queued when slot 3 is driven
// and compared by a monitor whenever frame_valid pulses.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] din;
  logic       din_valid, frame_start;
  logic [1:0] a, b, c, d, sel;
  logic       busy, frame_valid, frame_err;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_frames = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_abcd = 8'd0;

`ifdef TDM_DEMUX_TIMEOUT_EN
  localparam int GAP = 7;
`else
  localparam int GAP = 3;
`endif

  tdm_demux #(.WIDTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .frame_start(frame_start), .a(a), .b(b), .c(c), .d(d), .sel(sel),
    .busy(busy), .frame_valid(frame_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string t, input logic [1:0] s, input logic bz,
                    input logic fv, input logic fe);
    check({t, "_sel"}, {30'd0, sel}, {30'd0, s});
    check({t, "_busy"}, {31'd0, busy}, {31'd0, bz});
    check({t, "_fv"}, {31'd0, frame_valid}, {31'd0, fv});
    check({t, "_fe"}, {31'd0, frame_err}, {31'd0, fe});
  endtask

  task automatic hold(input string t);
    check(t, {24'd0, a, b, c, d}, {24'd0, last_abcd});
  endtask

  // One beat: drive at negedge, DUT samples at posedge, return at next negedge
  task automatic step(input logic v, input logic fs, input logic [1:0] dv);
    din_valid   = v;
    frame_start = fs;
    din         = dv;
    @(posedge clk);
    @(negedge clk);
    din_valid   = 1'b0;
    frame_start = 1'b0;
    din         = 2'd0;
  endtask

  // Monitor: pop scoreboard on every commit
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("fv_unexpected", 32'd1, 32'd0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("frame", {24'd0, a, b, c, d}, {24'd0, e});
        last_abcd = e;
        n_frames++;
      end
    end
    if (frame_valid === 1'b1 || frame_err === 1'b1)
      check("excl", {31'd0, frame_valid & frame_err}, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r;
    rst_n = 1'b0; din = 2'd0; din_valid = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    hold("rst_abcd");
    st("rst", 2'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame
    step(1'b1, 1'b1, 2'b11); st("s1", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b10); st("s2", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b01); st("s3", 2'd3, 1'b1, 1'b0, 1'b0); hold("s3_hold");
    exp_q.push_back(8'b11_10_01_00);
    step(1'b1, 1'b0, 2'b00); st("s4", 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'b00); st("s5", 2'd0, 1'b0, 1'b0, 1'b0);

    // Gapped frame
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    for (int i = 0; i < GAP; i++) begin
      step(1'b0, 1'b0, 2'b00); st("gap", 2'd2, 1'b1, 1'b0, 1'b0);
    end
    step(1'b1, 1'b0, 2'b01); st("gap_s3", 2'd3, 1'b1, 1'b0, 1'b0);
    exp_q.push_back(8'b11_10_01_00);
    step(1'b1, 1'b0, 2'b00); st("gap_c", 2'd0, 1'b0, 1'b1, 1'b0);

    // Back-to-back frames
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    exp_q.push_back(8'b00_01_10_11);
    step(1'b1, 1'b0, 2'b11); st("b2b_c1", 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'b01); st("b2b_n", 2'd1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b00);
    exp_q.push_back(8'b01_11_00_10);
    step(1'b1, 1'b0, 2'b10); st("b2b_c2", 2'd0, 1'b0, 1'b1, 1'b0);

    // Restart at slot 2
    step(1'b1, 1'b1, 2'b11);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b1, 2'b01); st("rs", 2'd1, 1'b1, 1'b0, 1'b1); hold("rs_hold");
    step(1'b1, 1'b0, 2'b00); st("rs_2", 2'd2, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'b11); st("rs_3", 2'd3, 1'b1, 1'b0, 1'b0); hold("rs_hold3");
    exp_q.push_back(8'b01_00_11_10);
    step(1'b1, 1'b0, 2'b10); st("rs_c", 2'd0, 1'b0, 1'b1, 1'b0);

    // Restart at slot 3
    step(1'b1, 1'b1, 2'b00);
    step(1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b0, 2'b10); st("rs3_pre", 2'd3, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b11); st("rs3", 2'd1, 1'b1, 1'b0, 1'b1); hold("rs3_hold");
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b01);
    exp_q.push_back(8'b11_10_01_00);
    step(1'b1, 1'b0, 2'b00); st("rs3_c", 2'd0, 1'b0, 1'b1, 1'b0);

    // Idle noise
    for (int i = 0; i < 5; i++) begin
      r = 2'($urandom_range(3));
      step(1'b1, 1'b0, r); st("noise", 2'd0, 1'b0, 1'b0, 1'b0); hold("noise_hold");
    end

    // Asynchronous reset mid-frame
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b01); st("pre_arst", 2'd2, 1'b1, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    last_abcd = 8'd0;
    hold("arst_abcd");
    st("arst", 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 2'b11); st("post_nofs", 2'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'b01);
    step(1'b1, 1'b0, 2'b10);
    step(1'b1, 1'b0, 2'b11);
    exp_q.push_back(8'b01_10_11_00);
    step(1'b1, 1'b0, 2'b00); st("post_c", 2'd0, 1'b0, 1'b1, 1'b0);

    // Long gap: timeout when compiled in, indefinite wait otherwise
    step(1'b1, 1'b1, 2'b10);
    step(1'b1, 1'b0, 2'b11);
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b0, 2'b00);
`ifdef TDM_DEMUX_TIMEOUT_EN
      if (i < 8) st("to_wait", 2'd2, 1'b1, 1'b0, 1'b0);
      else       st("to", 2'd0, 1'b0, 1'b0, 1'b1);
`else
      st("to_wait", 2'd2, 1'b1, 1'b0, 1'b0);
`endif
      hold("to_hold");
    end
    step(1'b1, 1'b1, 2'b00);
`ifdef TDM_DEMUX_TIMEOUT_EN
    st("to_new", 2'd1, 1'b1, 1'b0, 1'b0);
`else
    st("to_new", 2'd1, 1'b1, 1'b0, 1'b1);
`endif
    step(1'b1, 1'b0, 2'b11);
    step(1'b1, 1'b0, 2'b01);
    exp_q.push_back(8'b00_11_01_10);
    step(1'b1, 1'b0, 2'b10); st("to_c", 2'd0, 1'b0, 1'b1, 1'b0);

    step(1'b0, 1'b0, 2'b00);
    check("q_empty", exp_q.size(), 32'd0);
    check("frames", n_frames, 32'd8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
